// File: rtl/condicionador_controles.sv
// rtl/condicionador_controles.sv - synchronize, debounce and pulse-condition menu controls.
// Define CONDICIONADOR_AUTO_REPEAT_EN to enable the ESPERA/REPETE auto-repeat timer.
module condicionador_controles #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] controle_vertical,
  input  logic [1:0] controle_horizontal,
  input  logic       confirma,
  output logic [1:0] controle_vertical_out,
  output logic [1:0] controle_horizontal_out,
  output logic       confirma_pulso,
  output logic       movimento_pulso,
  output logic [1:0] db_estado
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    REPETE = 2'd2
  } estado_t;

  logic [4:0]    sync1, sync2;
  logic [1:0]    raw [3];
  logic [1:0]    cand [3];
  logic [1:0]    acc [3];
  logic [DW-1:0] cnt [3];
  logic          confirma_q;
  logic [3:0]    vetor, vetor_q;
  logic          mudanca, repete_pulso;
  estado_t       estado, estado_n;

  // 2'b11 means both directions at once; treat it as no movement
  always_comb begin
    raw[0] = (sync2[4:3] == 2'b11) ? 2'b00 : sync2[4:3];
    raw[1] = (sync2[2:1] == 2'b11) ? 2'b00 : sync2[2:1];
    raw[2] = {1'b0, sync2[0]};
  end

  // cand tracks the synchronized value; acc updates once cand has been
  // stable and different from acc for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      for (int i = 0; i < 3; i++) begin
        cand[i] <= '0;
        acc[i]  <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      sync1 <= {controle_vertical, controle_horizontal, confirma};
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        cand[i] <= raw[i];
        if (raw[i] != cand[i] || cand[i] == acc[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          acc[i] <= cand[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign controle_vertical_out   = acc[0];
  assign controle_horizontal_out = acc[1];
  assign vetor                   = {acc[0], acc[1]};
  assign mudanca                 = (vetor != 4'd0) && (vetor != vetor_q);
  assign confirma_pulso          = acc[2][0] & ~confirma_q;
  assign movimento_pulso         = mudanca | repete_pulso;
  assign db_estado               = estado;

`ifdef CONDICIONADOR_AUTO_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  logic [TW-1:0] timer, timer_n, timer_inc;

  assign timer_inc = (timer == TW'(TMAX)) ? timer : timer + 1'b1;

  // timer restarts at 1 on every emitted pulse, so a match means the full
  // delay/period has elapsed since that pulse
  always_comb begin
    estado_n     = estado;
    timer_n      = timer;
    repete_pulso = 1'b0;
    if (vetor == 4'd0) begin
      estado_n = OCIOSO;
      timer_n  = '0;
    end else if (mudanca) begin
      estado_n = ESPERA;
      timer_n  = TW'(1);
    end else begin
      case (estado)
        ESPERA: begin
          if (timer == TW'(REPEAT_DELAY)) begin
            repete_pulso = 1'b1;
            estado_n     = REPETE;
            timer_n      = TW'(1);
          end else begin
            timer_n = timer_inc;
          end
        end
        REPETE: begin
          if (timer == TW'(REPEAT_PERIOD)) begin
            repete_pulso = 1'b1;
            timer_n      = TW'(1);
          end else begin
            timer_n = timer_inc;
          end
        end
        default: timer_n = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
    end else begin
      timer <= timer_n;
    end
  end
`else
  always_comb begin
    repete_pulso = 1'b0;
    estado_n     = (vetor == 4'd0) ? OCIOSO : ESPERA;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= OCIOSO;
      vetor_q    <= '0;
      confirma_q <= 1'b0;
    end else begin
      estado     <= estado_n;
      vetor_q    <= vetor;
      confirma_q <= acc[2][0];
    end
  end

endmodule

// File: tb/tb_condicionador_controles.sv
// tb/tb_condicionador_controles.sv - directed bench for condicionador_controles.
module tb_condicionador_controles;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cv = 2'b00, ch = 2'b00;
  logic       cf = 1'b0;
  logic [1:0] v_out, h_out, estado;
  logic       conf_p, mov_p;

  int checks = 0;
  int errors = 0;

  condicionador_controles #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .controle_vertical(cv),
    .controle_horizontal(ch),
    .confirma(cf),
    .controle_vertical_out(v_out),
    .controle_horizontal_out(h_out),
    .confirma_pulso(conf_p),
    .movimento_pulso(mov_p),
    .db_estado(estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [1:0] v, h;
    logic       c;
    int         hold;
    logic [31:0] mov_mask, conf_mask;
    int         probe;
    logic [1:0] pv, ph, pst;
  } vec_t;

  vec_t tbl [6];

`ifdef CONDICIONADOR_AUTO_REPEAT_EN
  localparam logic [31:0] MOV_HOLD   = 32'h2492_0080;
  localparam logic [31:0] MOV_CHANGE = 32'h2401_0080;
  localparam logic [1:0]  ST_LATE    = 2'd2;
`else
  localparam logic [31:0] MOV_HOLD   = 32'h0000_0080;
  localparam logic [31:0] MOV_CHANGE = 32'h0001_0080;
  localparam logic [1:0]  ST_LATE    = 2'd1;
`endif

  function automatic vec_t mk(input string n, input logic [1:0] v, input logic [1:0] h,
                              input logic c, input int hold, input logic [31:0] mm,
                              input logic [31:0] cm, input int probe, input logic [1:0] pv,
                              input logic [1:0] ph, input logic [1:0] pst);
    vec_t r;
    r.name = n; r.v = v; r.h = h; r.c = c; r.hold = hold;
    r.mov_mask = mm; r.conf_mask = cm; r.probe = probe;
    r.pv = pv; r.ph = ph; r.pst = pst;
    return r;
  endfunction

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cv = 2'b00; ch = 2'b00; cf = 1'b0;
    repeat (2) step();
    chk("reset v_out", {6'd0, v_out}, 8'd0);
    chk("reset h_out", {6'd0, h_out}, 8'd0);
    chk("reset conf", {7'd0, conf_p}, 8'd0);
    chk("reset mov", {7'd0, mov_p}, 8'd0);
    chk("reset estado", {6'd0, estado}, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = mk("confirma", 2'b00, 2'b00, 1'b1, 20, 32'h0, 32'h80, 10, 2'b00, 2'b00, 2'd0);
    tbl[1] = mk("glitch",   2'b01, 2'b00, 1'b0, 3,  32'h0, 32'h0, 20, 2'b00, 2'b00, 2'd0);
    tbl[2] = mk("horiz_e7", 2'b00, 2'b10, 1'b0, 32, MOV_HOLD, 32'h0, 7, 2'b00, 2'b10, 2'd0);
    tbl[3] = mk("horiz_e12",2'b00, 2'b10, 1'b0, 32, MOV_HOLD, 32'h0, 12, 2'b00, 2'b10, 2'd1);
    tbl[4] = mk("horiz_e25",2'b00, 2'b10, 1'b0, 32, MOV_HOLD, 32'h0, 25, 2'b00, 2'b10, ST_LATE);
    tbl[5] = mk("both_01",  2'b01, 2'b01, 1'b0, 32, MOV_HOLD, 32'h0, 8, 2'b01, 2'b01, 2'd1);

    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int e = 0; e < 32; e++) begin
        if (e < tbl[s].hold) begin
          cv = tbl[s].v; ch = tbl[s].h; cf = tbl[s].c;
        end else begin
          cv = 2'b00; ch = 2'b00; cf = 1'b0;
        end
        step();
        chk($sformatf("%s mov@%0d", tbl[s].name, e), {7'd0, mov_p}, {7'd0, tbl[s].mov_mask[e]});
        chk($sformatf("%s conf@%0d", tbl[s].name, e), {7'd0, conf_p}, {7'd0, tbl[s].conf_mask[e]});
        if (e == tbl[s].probe) begin
          chk($sformatf("%s v_out@%0d", tbl[s].name, e), {6'd0, v_out}, {6'd0, tbl[s].pv});
          chk($sformatf("%s h_out@%0d", tbl[s].name, e), {6'd0, h_out}, {6'd0, tbl[s].ph});
          chk($sformatf("%s estado@%0d", tbl[s].name, e), {6'd0, estado}, {6'd0, tbl[s].pst});
        end
      end
    end

    // both directions on one axis collapses to no movement
    do_reset();
    cv = 2'b11;
    for (int e = 0; e < 16; e++) begin
      step();
      chk($sformatf("v11 mov@%0d", e), {7'd0, mov_p}, 8'd0);
      chk($sformatf("v11 v_out@%0d", e), {6'd0, v_out}, 8'd0);
    end

    // reset in the middle of a held input
    do_reset();
    ch = 2'b10;
    for (int e = 0; e < 12; e++) begin
      step();
      chk($sformatf("rst mov@%0d", e), {7'd0, mov_p}, {7'd0, (e == 7)});
    end
    reset = 1'b1;
    step();
    chk("rst mid h_out", {6'd0, h_out}, 8'd0);
    chk("rst mid mov", {7'd0, mov_p}, 8'd0);
    chk("rst mid estado", {6'd0, estado}, 8'd0);
    reset = 1'b0;
    for (int e = 13; e < 25; e++) begin
      step();
      chk($sformatf("rst re mov@%0d", e), {7'd0, mov_p}, {7'd0, (e == 20)});
      if (e == 19) chk("rst re h_out@19", {6'd0, h_out}, 8'd0);
      if (e == 20) chk("rst re h_out@20", {6'd0, h_out}, 8'd2);
    end

    // change to a different nonzero vector pulses at once and restarts the delay
    do_reset();
    for (int e = 0; e < 31; e++) begin
      ch = (e < 9) ? 2'b10 : 2'b01;
      step();
      chk($sformatf("chg mov@%0d", e), {7'd0, mov_p}, {7'd0, MOV_CHANGE[e]});
      if (e == 16) chk("chg h_out@16", {6'd0, h_out}, 8'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/condicionador_controles.md
CONDICIONADOR_CONTROLES -- requirements
Module: condicionador_controles

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a new input value.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from the first movement pulse to the first repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between later repeat pulses.
REQ-004 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port controle_vertical  input  2  raw asynchronous vertical switch pair.
REQ-007 SHALL have port controle_horizontal  input  2  raw asynchronous horizontal switch pair.
REQ-008 SHALL have port confirma  input  1  raw asynchronous confirm button.
REQ-009 SHALL have port controle_vertical_out  output  2  debounced vertical code.
REQ-010 SHALL have port controle_horizontal_out  output  2  debounced horizontal code.
REQ-011 SHALL have port confirma_pulso  output  1  one-cycle pulse on each accepted confirm press.
REQ-012 SHALL have port movimento_pulso  output  1  one-cycle movement request (initial or repeat).
REQ-013 SHALL have port db_estado  output  2  repeat FSM state: 0 OCIOSO, 1 ESPERA, 2 REPETE.

Function
REQ-014 SHALL pass each raw input through a two-flop synchronizer before any other logic.
REQ-015 SHALL map control code 2'b11 (both directions) to 2'b00 at the synchronizer output, before debouncing.
REQ-016 SHALL debounce three independent channels (vertical pair, horizontal pair, confirma), each with its own counter; any change of the synchronized value from the last accepted value restarts the channel counter at 0.
REQ-017 SHALL accept a channel value once it has differed from the accepted value, unchanged, for DEBOUNCE_CYCLES consecutive cycles; a raw change held stable appears on the output exactly DEBOUNCE_CYCLES+3 rising edges later.
REQ-018 SHALL not accept a glitch shorter than DEBOUNCE_CYCLES cycles; the output holds its previous value.
REQ-019 SHALL assert confirma_pulso for exactly one cycle, in the same cycle the accepted confirma changes 0->1; no pulse on release.
REQ-020 SHALL define the direction vector as {controle_vertical_out, controle_horizontal_out}; movimento_pulso SHALL be asserted for one cycle, in the cycle the accepted vector changes to a nonzero value (from zero or from another nonzero value).
REQ-021 SHALL produce only one movimento_pulso when vertical and horizontal are accepted in the same cycle.
REQ-022 SHALL run the FSM as follows: OCIOSO -> ESPERA on an initial pulse; ESPERA -> REPETE after REPEAT_DELAY cycles with the vector unchanged, emitting a pulse; REPETE pulses every REPEAT_PERIOD cycles; any state -> OCIOSO when the vector becomes zero; a change to a different nonzero vector pulses immediately and re-enters ESPERA with the timer cleared.
REQ-023 SHALL size the repeat timer to hold max(REPEAT_DELAY, REPEAT_PERIOD) without wrap; the timer saturates and never wraps.

Reset
REQ-024 SHALL, while reset is high on a clock edge, clear synchronizers, accepted values, debounce counters and the repeat timer to 0, and set the FSM to OCIOSO.
REQ-025 SHALL, during and after reset, hold all outputs at 0 (db_estado = 0) until new values are accepted per REQ-017.
REQ-026 SHALL discard any debounce or repeat in progress when reset arrives mid-operation; an input held through reset is re-accepted DEBOUNCE_CYCLES+3 edges after reset falls, and the first movement pulse is issued at that point.

Configuration
REQ-027 SHALL, with macro CONDICIONADOR_AUTO_REPEAT_EN defined, implement the ESPERA/REPETE repeat behaviour of REQ-022.
REQ-028 SHALL, without CONDICIONADOR_AUTO_REPEAT_EN, omit the repeat timer; movimento_pulso fires only per REQ-020, the FSM uses only OCIOSO (0) and ESPERA (1, vector nonzero), and REPETE is never reported.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 SHALL check: confirma raised at edge 0 and held -> confirma_pulso high only at edge 7; confirma_pulso stays low on release.
REQ-030 SHALL check: controle_vertical=01 for 3 cycles, then 00 -> controle_vertical_out stays 00 and movimento_pulso never fires.
REQ-031 SHALL check: controle_horizontal=10 held, macro defined -> pulses at edges 7, 17, 20, 23; db_estado sequence 0->1->2.
REQ-032 SHALL check: vertical 01 and horizontal 01 raised at the same edge -> exactly one pulse, at edge 7; an input of 11 yields output 00 with no pulse.
REQ-033 SHALL check: reset asserted at edge 12 with the input held -> all outputs 0 and db_estado 0 at the next edge; after reset falls, the output is re-accepted 7 edges later with a single pulse.
REQ-034 SHALL check: macro undefined, horizontal=10 held for 40 cycles -> a single pulse at edge 7; db_estado holds 1.
